// File: rtl/mul_pipe_pkg.sv
// ----------------------------------------------------------------------------
// mul_pipe_pkg
// Shared definitions for the 8-bit multiplier pipeline and its accumulator
// stage: default widths, the accumulator FSM state type and the add helper
// used for every product absorbed by mul_acc_stage.
// ----------------------------------------------------------------------------
package mul_pipe_pkg;

    // Product width produced by the multiplier (2 * 8-bit operands).
    localparam int IN_W_DEF    = 16;
    // Default frame length in valid products.
    localparam int VEC_LEN_DEF = 8;
    // Width of the per-frame product counter for the default frame length.
    localparam int CNT_W       = $clog2(VEC_LEN_DEF + 1);
    // Widest accumulator the add helper supports.
    localparam int SUM_MAX_W   = 64;

    // Frame state, derived from the number of products absorbed so far.
    typedef enum logic {
        ST_IDLE  = 1'b0,   // no product absorbed in the current frame
        ST_ACCUM = 1'b1    // 0 < count < VEC_LEN
    } acc_state_t;

    // Result of one accumulate step.
    typedef struct packed {
        logic                 sat;   // sum did not fit in acc_w bits
        logic [SUM_MAX_W-1:0] sum;   // new accumulator value (low acc_w bits valid)
    } sat_sum_t;

    // Adds an increment to the accumulator with one extra carry bit.
    // Both operands are zero-extended and are assumed to already be below
    // 2^acc_w. On overflow the sat flag is set and the sum either clamps to
    // the all-ones value or keeps its low acc_w bits (modulo wrap).
    function automatic sat_sum_t sat_add(
        input logic [SUM_MAX_W-1:0] acc,
        input logic [SUM_MAX_W-1:0] inc,
        input int unsigned          acc_w,
        input logic                 saturate
    );
        logic [SUM_MAX_W:0] full;
        logic [SUM_MAX_W:0] limit;
        logic [SUM_MAX_W:0] wrapped;
        sat_sum_t           res;
        full    = {1'b0, acc} + {1'b0, inc};
        limit   = ({{SUM_MAX_W{1'b0}}, 1'b1} << acc_w) - 1'b1;
        wrapped = full & limit;
        res.sat = (full > limit);
        if (!res.sat) begin
            res.sum = full[SUM_MAX_W-1:0];
        end else if (saturate) begin
            res.sum = limit[SUM_MAX_W-1:0];
        end else begin
            res.sum = wrapped[SUM_MAX_W-1:0];
        end
        return res;
    endfunction

endpackage : mul_pipe_pkg

// File: rtl/mul_acc_stage_if.sv
// ----------------------------------------------------------------------------
// mul_acc_stage_if
// Bundles the product input, control strobes and the result valid/ready port
// of mul_acc_stage.
//   master : the surrounding system (multiplier, controller, result consumer)
//   slave  : mul_acc_stage itself
// Signals:
//   mul_en_out / mul_out   product strobe and unsigned product
//   frame_clr / err_clr    abort current frame / clear sticky overrun flag
//   acc_out / acc_sat      frame result and its saturation flag
//   acc_valid / acc_ready  result handshake
//   acc_cnt                products absorbed in the current frame
//   ovr_err                sticky overrun flag
// ----------------------------------------------------------------------------
interface mul_acc_stage_if
    import mul_pipe_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = 24,
    parameter int CNT_W = mul_pipe_pkg::CNT_W
);
    logic             mul_en_out;
    logic [IN_W-1:0]  mul_out;
    logic             frame_clr;
    logic             err_clr;
    logic [ACC_W-1:0] acc_out;
    logic             acc_sat;
    logic             acc_valid;
    logic             acc_ready;
    logic [CNT_W-1:0] acc_cnt;
    logic             ovr_err;

    modport master (
        output mul_en_out, mul_out, frame_clr, err_clr, acc_ready,
        input  acc_out, acc_sat, acc_valid, acc_cnt, ovr_err
    );

    modport slave (
        input  mul_en_out, mul_out, frame_clr, err_clr, acc_ready,
        output acc_out, acc_sat, acc_valid, acc_cnt, ovr_err
    );
endinterface : mul_acc_stage_if

// File: rtl/mul_acc_out_reg.sv
// ----------------------------------------------------------------------------
// mul_acc_out_reg
// One-entry valid/ready holding register for a completed frame result
// {sat, data}. Owns the sticky overrun flag.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_load          a frame completed this cycle; i_data/i_sat carry it
//   i_data, i_sat   completed result and its saturation flag
//   i_ready         downstream accepts when o_valid & i_ready
//   i_err_clr       clears o_ovr_err (a simultaneous overrun wins)
//   o_valid         result held and offered downstream
//   o_data, o_sat   held result, stable while o_valid & !i_ready
//   o_ovr_err       sticky: a result arrived while the entry was occupied
// ----------------------------------------------------------------------------
module mul_acc_out_reg #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_sat,
    input  logic              i_ready,
    input  logic              i_err_clr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sat,
    output logic              o_ovr_err
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_sat;
    logic              r_ovr_err;

    logic w_accept;    // current entry leaves on this edge
    logic w_can_load;  // entry is free, or is being freed on this edge
    logic w_overrun;   // new result finds the entry occupied and stalled

    assign w_accept   = r_valid & i_ready;
    assign w_can_load = ~r_valid | i_ready;
    assign w_overrun  = i_load & ~w_can_load;

    // NOTE: the payload is reset as well as the valid bit, so every output
    // reads 0 straight out of reset rather than a stale or unknown value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sat   <= 1'b0;
        end else if (i_load && w_can_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_sat   <= i_sat;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_err <= 1'b0;
        end else if (w_overrun) begin
            r_ovr_err <= 1'b1;
        end else if (i_err_clr) begin
            r_ovr_err <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_sat     = r_sat;
    assign o_ovr_err = r_ovr_err;

endmodule : mul_acc_out_reg

// File: rtl/mul_acc_stage.sv
// ----------------------------------------------------------------------------
// mul_acc_stage
// Accumulates VEC_LEN consecutive valid products from the 8-bit pipelined
// multiplier into a dot-product and hands each result off through a
// registered valid/ready port. The input is never stalled: a result that
// completes while the output is still occupied is dropped and flagged.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  product strobe/data, frame_clr, err_clr, result handshake,
//                acc_cnt and ovr_err (see mul_acc_stage_if)
// Parameters:
//   IN_W     product width
//   VEC_LEN  valid products per frame (>= 2)
//   ACC_W    accumulator/result width (>= IN_W, <= 64)
//   SATURATE 1 = clamp at all-ones, 0 = modulo wrap; overflow sets acc_sat
// ----------------------------------------------------------------------------
module mul_acc_stage
    import mul_pipe_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int VEC_LEN  = VEC_LEN_DEF,
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    mul_acc_stage_if.slave bus
);

    localparam int CW = $clog2(VEC_LEN + 1);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [CW-1:0]    r_cnt;

    sat_sum_t         w_add;
    logic [ACC_W-1:0] w_sum;
    logic             w_sat_frame;  // sat flag including this product
    logic             w_last;       // the next product completes the frame
    logic             w_done;       // frame completes on this edge

    logic [ACC_W-1:0] w_acc_out;
    logic             w_acc_sat;
    logic             w_acc_valid;
    logic             w_ovr_err;

    // ------------------------------------------------------------------
    // Accumulate step
    // ------------------------------------------------------------------
    assign w_add       = sat_add(SUM_MAX_W'(r_acc), SUM_MAX_W'(bus.mul_out),
                                 ACC_W, SATURATE);
    assign w_sum       = w_add.sum[ACC_W-1:0];
    assign w_sat_frame = r_sat | w_add.sat;

    // Upper bits of the helper's sum are always zero for this ACC_W.
    generate
        if (ACC_W < SUM_MAX_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = |w_add.sum[SUM_MAX_W-1:ACC_W];
        end
    endgenerate

    assign w_last = (r_cnt == CW'(VEC_LEN - 1));
    // frame_clr on the completion edge discards the completion.
    assign w_done = bus.mul_en_out & ~bus.frame_clr &
                    (r_state == ST_ACCUM) & w_last;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next state gets its default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.frame_clr) begin
            w_state_nxt = ST_IDLE;
        end else if (bus.mul_en_out) begin
            unique case (r_state)
                ST_IDLE:  w_state_nxt = ST_ACCUM;
                ST_ACCUM: if (w_last) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accumulator, frame sat flag and product counter
    // ------------------------------------------------------------------
    // On completion everything returns to 0 on the same edge, so the next
    // frame can start with the very next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (bus.frame_clr || w_done) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (bus.mul_en_out) begin
            r_acc <= w_sum;
            r_sat <= w_sat_frame;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result holding register
    // ------------------------------------------------------------------
    mul_acc_out_reg #(
        .DATA_W (ACC_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_done),
        .i_data    (w_sum),
        .i_sat     (w_sat_frame),
        .i_ready   (bus.acc_ready),
        .i_err_clr (bus.err_clr),
        .o_valid   (w_acc_valid),
        .o_data    (w_acc_out),
        .o_sat     (w_acc_sat),
        .o_ovr_err (w_ovr_err)
    );

    assign bus.acc_out   = w_acc_out;
    assign bus.acc_sat   = w_acc_sat;
    assign bus.acc_valid = w_acc_valid;
    assign bus.acc_cnt   = r_cnt;
    assign bus.ovr_err   = w_ovr_err;

endmodule : mul_acc_stage

// File: tb/tb_mul_acc_stage.sv
// ----------------------------------------------------------------------------
// tb_mul_acc_stage
// Directed bench for mul_acc_stage. Three instances share one stimulus:
// the default configuration (ACC_W=24, saturating) plus two ACC_W=18
// instances, one saturating and one wrapping, to exercise overflow.
// ----------------------------------------------------------------------------
module tb_mul_acc_stage;

    logic        clk;
    logic        rst_n;
    logic        mul_en;
    logic [15:0] mul_val;
    logic        frame_clr;
    logic        err_clr;
    logic        ready;

    int checks = 0;
    int errors = 0;

    mul_acc_stage_if #(.IN_W(16), .ACC_W(24), .CNT_W(4)) bus_m ();
    mul_acc_stage_if #(.IN_W(16), .ACC_W(18), .CNT_W(4)) bus_s ();
    mul_acc_stage_if #(.IN_W(16), .ACC_W(18), .CNT_W(4)) bus_w ();

    assign bus_m.mul_en_out = mul_en;
    assign bus_m.mul_out    = mul_val;
    assign bus_m.frame_clr  = frame_clr;
    assign bus_m.err_clr    = err_clr;
    assign bus_m.acc_ready  = ready;

    assign bus_s.mul_en_out = mul_en;
    assign bus_s.mul_out    = mul_val;
    assign bus_s.frame_clr  = frame_clr;
    assign bus_s.err_clr    = err_clr;
    assign bus_s.acc_ready  = ready;

    assign bus_w.mul_en_out = mul_en;
    assign bus_w.mul_out    = mul_val;
    assign bus_w.frame_clr  = frame_clr;
    assign bus_w.err_clr    = err_clr;
    assign bus_w.acc_ready  = ready;

    mul_acc_stage #(.IN_W(16), .VEC_LEN(8), .ACC_W(24), .SATURATE(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    mul_acc_stage #(.IN_W(16), .VEC_LEN(8), .ACC_W(18), .SATURATE(1'b1)) u_dut_sat18 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    mul_acc_stage #(.IN_W(16), .VEC_LEN(8), .ACC_W(18), .SATURATE(1'b0)) u_dut_wrap18 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int gaps [8] = '{0, 1, 2, 3, 0, 3, 1, 2};

    initial begin
        rst_n     = 1'b0;
        mul_en    = 1'b0;
        mul_val   = 16'h0;
        frame_clr = 1'b0;
        err_clr   = 1'b0;
        ready     = 1'b1;
        #12;
        rst_n = 1'b1;
        tick();

        // ---- reset state ----
        check("rst_valid", 32'(bus_m.acc_valid), 32'd0);
        check("rst_out",   32'(bus_m.acc_out),   32'd0);
        check("rst_sat",   32'(bus_m.acc_sat),   32'd0);
        check("rst_cnt",   32'(bus_m.acc_cnt),   32'd0);
        check("rst_ovr",   32'(bus_m.ovr_err),   32'd0);

        // ---- 8 back-to-back strobes of 255*255 ----
        mul_en  = 1'b1;
        mul_val = 16'd65025;
        repeat (7) tick();
        check("t1_cnt7",   32'(bus_m.acc_cnt),   32'd7);
        check("t1_early",  32'(bus_m.acc_valid), 32'd0);
        tick();
        mul_en = 1'b0;
        check("t1_valid",  32'(bus_m.acc_valid), 32'd1);
        check("t1_out",    32'(bus_m.acc_out),   32'd520200);
        check("t1_sat",    32'(bus_m.acc_sat),   32'd0);
        check("t1_cnt0",   32'(bus_m.acc_cnt),   32'd0);
        check("s18_out",   32'(bus_s.acc_out),   32'd262143);
        check("s18_sat",   32'(bus_s.acc_sat),   32'd1);
        check("w18_out",   32'(bus_w.acc_out),   32'd258056);
        check("w18_sat",   32'(bus_w.acc_sat),   32'd1);
        tick();
        check("t1_drop",   32'(bus_m.acc_valid), 32'd0);

        // ---- products 1..8 with idle gaps carrying 0xFFFF ----
        for (int i = 0; i < 8; i++) begin
            mul_en  = 1'b0;
            mul_val = 16'hFFFF;
            repeat (gaps[i]) tick();
            mul_en  = 1'b1;
            mul_val = 16'(i + 1);
            tick();
            if (i == 3) check("t2_cnt4", 32'(bus_m.acc_cnt), 32'd4);
        end
        mul_en  = 1'b0;
        mul_val = 16'hFFFF;
        check("t2_valid",  32'(bus_m.acc_valid), 32'd1);
        check("t2_out",    32'(bus_m.acc_out),   32'd36);
        check("t2_sat",    32'(bus_m.acc_sat),   32'd0);
        tick();
        check("t2_drop",   32'(bus_m.acc_valid), 32'd0);

        // ---- overrun with output stalled ----
        ready   = 1'b0;
        mul_en  = 1'b1;
        mul_val = 16'd1;
        repeat (8) tick();
        check("t3_valid",  32'(bus_m.acc_valid), 32'd1);
        check("t3_out8",   32'(bus_m.acc_out),   32'd8);
        check("t3_ovr0",   32'(bus_m.ovr_err),   32'd0);
        repeat (7) tick();
        check("t3_ovr15",  32'(bus_m.ovr_err),   32'd0);
        err_clr = 1'b1;             // coincides with the overrun: set wins
        tick();
        err_clr = 1'b0;
        mul_en  = 1'b0;
        check("t3_ovr1",   32'(bus_m.ovr_err),   32'd1);
        check("t3_hold",   32'(bus_m.acc_out),   32'd8);
        check("t3_cnt0",   32'(bus_m.acc_cnt),   32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_clr",    32'(bus_m.ovr_err),   32'd0);
        check("t3_still",  32'(bus_m.acc_valid), 32'd1);
        check("t3_out_hd", 32'(bus_m.acc_out),   32'd8);
        ready = 1'b1;
        tick();
        check("t3_accept", 32'(bus_m.acc_valid), 32'd0);

        // ---- frame_clr mid-frame with a coincident product ----
        mul_en  = 1'b1;
        mul_val = 16'd10;
        repeat (3) tick();
        check("t4_cnt3",   32'(bus_m.acc_cnt),   32'd3);
        frame_clr = 1'b1;
        tick();
        frame_clr = 1'b0;
        check("t4_cnt0",   32'(bus_m.acc_cnt),   32'd0);
        check("t4_novld",  32'(bus_m.acc_valid), 32'd0);
        mul_val = 16'd2;
        repeat (7) tick();
        check("t4_early",  32'(bus_m.acc_valid), 32'd0);
        tick();
        mul_en = 1'b0;
        check("t4_valid",  32'(bus_m.acc_valid), 32'd1);
        check("t4_out",    32'(bus_m.acc_out),   32'd16);
        tick();
        check("t4_drop",   32'(bus_m.acc_valid), 32'd0);

        // ---- asynchronous reset mid-frame with a result pending ----
        ready   = 1'b0;
        mul_en  = 1'b1;
        mul_val = 16'd1;
        repeat (8) tick();
        check("t5_pend",   32'(bus_m.acc_valid), 32'd1);
        mul_val = 16'd7;
        repeat (5) tick();
        mul_en = 1'b0;
        check("t5_cnt5",   32'(bus_m.acc_cnt),   32'd5);
        #1 rst_n = 1'b0;
        #1;
        check("t5_valid0", 32'(bus_m.acc_valid), 32'd0);
        check("t5_out0",   32'(bus_m.acc_out),   32'd0);
        check("t5_cnt0",   32'(bus_m.acc_cnt),   32'd0);
        check("t5_sat0",   32'(bus_m.acc_sat),   32'd0);
        check("t5_ovr0",   32'(bus_m.ovr_err),   32'd0);
        #1 rst_n = 1'b1;
        ready   = 1'b1;
        mul_en  = 1'b1;
        mul_val = 16'd3;
        repeat (8) tick();
        mul_en = 1'b0;
        check("t5_valid",  32'(bus_m.acc_valid), 32'd1);
        check("t5_out",    32'(bus_m.acc_out),   32'd24);
        check("t5_sat",    32'(bus_m.acc_sat),   32'd0);
        tick();
        check("t5_drop",   32'(bus_m.acc_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_acc_stage
